price_level_scanner: RTL and testbench

PRICE_LEVEL_SCANNER -- requirements
Module: price_level_scanner

---
 rtl/price_book_pkg.sv | 14 +
 rtl/price_better.sv | 16 +
 rtl/price_level_scanner.sv | 145 ++++++++++++++
 tb/tb_price_level_scanner.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/price_book_pkg.sv
// rtl/price_book_pkg.sv - shared widths and scan state encoding for price book blocks
package price_book_pkg;

  localparam int PRICE_W = 64;
  localparam int QTY_W   = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_e;

endpackage

// File: rtl/price_better.sv
// rtl/price_better.sv - combinational strict price comparison (bid: higher wins, ask: lower wins)
module price_better
  import price_book_pkg::*;
#(
  parameter int W = PRICE_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         is_bid,
  output logic         better
);

  // Strict comparison so equal prices never displace an earlier entry.
  assign better = is_bid ? (a > b) : (a < b);

endmodule

// File: rtl/price_level_scanner.sv
// rtl/price_level_scanner.sv - sequential scan of external level storage for best price
module price_level_scanner
  import price_book_pkg::*;
#(
  parameter int NUM_LEVELS = 16,
  parameter bit IS_BID     = 1'b1,
  parameter int IDX_W      = $clog2(NUM_LEVELS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic [IDX_W-1:0]   rd_index,
  input  logic [PRICE_W-1:0] rd_price,
  input  logic [QTY_W-1:0]   rd_quantity,
  input  logic               rd_valid,
  output logic [PRICE_W-1:0] best_price,
  output logic [QTY_W-1:0]   best_quantity,
  output logic [IDX_W-1:0]   best_index,
  output logic               best_found,
  output logic               out_valid,
  input  logic               out_ready
);

  scan_state_e        state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   cmp_idx_q;
  logic               cmp_en_q;
  logic               busy_q;
  logic               out_valid_q;

  logic               run_found_q, run_found_d;
  logic [PRICE_W-1:0] run_price_q, run_price_d;
  logic [QTY_W-1:0]   run_qty_q,   run_qty_d;
  logic [IDX_W-1:0]   run_idx_q,   run_idx_d;

  logic               best_found_q;
  logic [PRICE_W-1:0] best_price_q;
  logic [QTY_W-1:0]   best_qty_q;
  logic [IDX_W-1:0]   best_idx_q;

  logic               is_better;
  logic               take;

  price_better #(.W(PRICE_W)) u_better (
    .a      (rd_price),
    .b      (run_price_q),
    .is_bid (IS_BID),
    .better (is_better)
  );

  // Compare stage works on the entry addressed one cycle earlier (cmp_idx_q).
  always_comb begin
    run_found_d = run_found_q;
    run_price_d = run_price_q;
    run_qty_d   = run_qty_q;
    run_idx_d   = run_idx_q;
    take        = cmp_en_q && rd_valid && (rd_quantity != '0) && (!run_found_q || is_better);
    if (take) begin
      run_found_d = 1'b1;
      run_price_d = rd_price;
      run_qty_d   = rd_quantity;
      run_idx_d   = cmp_idx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      cmp_idx_q    <= '0;
      cmp_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      run_found_q  <= 1'b0;
      run_price_q  <= '0;
      run_qty_q    <= '0;
      run_idx_q    <= '0;
      best_found_q <= 1'b0;
      best_price_q <= '0;
      best_qty_q   <= '0;
      best_idx_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q     <= ST_SCAN;
            idx_q       <= '0;
            cmp_en_q    <= 1'b0;
            busy_q      <= 1'b1;
            run_found_q <= 1'b0;
            run_price_q <= '0;
            run_qty_q   <= '0;
            run_idx_q   <= '0;
          end
        end
        ST_SCAN: begin
          cmp_en_q    <= 1'b1;
          cmp_idx_q   <= idx_q;
          run_found_q <= run_found_d;
          run_price_q <= run_price_d;
          run_qty_q   <= run_qty_d;
          run_idx_q   <= run_idx_d;
          if (idx_q == IDX_W'(NUM_LEVELS - 1)) begin
            state_q <= ST_FLUSH;
            idx_q   <= '0;
          end else begin
            idx_q   <= idx_q + IDX_W'(1);
          end
        end
        ST_FLUSH: begin
          // Last entry is folded in here and published straight to the outputs.
          cmp_en_q     <= 1'b0;
          run_found_q  <= run_found_d;
          run_price_q  <= run_price_d;
          run_qty_q    <= run_qty_d;
          run_idx_q    <= run_idx_d;
          best_found_q <= run_found_d;
          best_price_q <= run_price_d;
          best_qty_q   <= run_qty_d;
          best_idx_q   <= run_idx_d;
          busy_q       <= 1'b0;
          out_valid_q  <= 1'b1;
          state_q      <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign rd_index      = idx_q;
  assign out_valid     = out_valid_q;
  assign best_found    = best_found_q;
  assign best_price    = best_price_q;
  assign best_quantity = best_qty_q;
  assign best_index    = best_idx_q;

endmodule

// File: tb/tb_price_level_scanner.sv
// tb/tb_price_level_scanner.sv - randomized self-checking bench for price_level_scanner
module tb_price_level_scanner;

  localparam int N = 16;

  logic clk = 1'b0;
  logic reset_r, start_r, out_ready_r, sel_ask;

  logic [63:0] m_price [N];
  logic [63:0] m_qty   [N];
  logic        m_valid [N];

  logic        start_b, ready_b, busy_b, ov_b, found_b, rv_b;
  logic [3:0]  idx_b, bidx_b;
  logic [63:0] rp_b, rq_b, bp_b, bq_b;
  logic        start_a, ready_a, busy_a, ov_a, found_a, rv_a;
  logic [3:0]  idx_a, bidx_a;
  logic [63:0] rp_a, rq_a, bp_a, bq_a;

  logic        o_valid, o_busy, o_found;
  logic [3:0]  o_idx, o_bidx;
  logic [63:0] o_price, o_qty;

  logic        e_found;
  logic [63:0] e_price, e_qty, e_idx;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign start_b = start_r & ~sel_ask;
  assign start_a = start_r &  sel_ask;
  assign ready_b = out_ready_r & ~sel_ask;
  assign ready_a = out_ready_r &  sel_ask;

  assign o_valid = sel_ask ? ov_a    : ov_b;
  assign o_busy  = sel_ask ? busy_a  : busy_b;
  assign o_idx   = sel_ask ? idx_a   : idx_b;
  assign o_found = sel_ask ? found_a : found_b;
  assign o_price = sel_ask ? bp_a    : bp_b;
  assign o_qty   = sel_ask ? bq_a    : bq_b;
  assign o_bidx  = sel_ask ? bidx_a  : bidx_b;

  // Level storage with one cycle read latency, one port per scanner.
  always_ff @(posedge clk) begin
    rp_b <= m_price[idx_b];
    rq_b <= m_qty[idx_b];
    rv_b <= m_valid[idx_b];
    rp_a <= m_price[idx_a];
    rq_a <= m_qty[idx_a];
    rv_a <= m_valid[idx_a];
  end

  price_level_scanner #(.NUM_LEVELS(N), .IS_BID(1'b1)) dut_bid (
    .clk(clk), .reset(reset_r), .start(start_b), .busy(busy_b), .rd_index(idx_b),
    .rd_price(rp_b), .rd_quantity(rq_b), .rd_valid(rv_b),
    .best_price(bp_b), .best_quantity(bq_b), .best_index(bidx_b), .best_found(found_b),
    .out_valid(ov_b), .out_ready(ready_b)
  );

  price_level_scanner #(.NUM_LEVELS(N), .IS_BID(1'b0)) dut_ask (
    .clk(clk), .reset(reset_r), .start(start_a), .busy(busy_a), .rd_index(idx_a),
    .rd_price(rp_a), .rd_quantity(rq_a), .rd_valid(rv_a),
    .best_price(bp_a), .best_quantity(bq_a), .best_index(bidx_a), .best_found(found_a),
    .out_valid(ov_a), .out_ready(ready_a)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: best price value over qualifying entries, then the lowest index holding it.
  task automatic ref_best(input bit ask, output logic f, output logic [63:0] p,
                          output logic [63:0] q, output logic [63:0] ix);
    logic got;
    f = 1'b0; p = '0; q = '0; ix = '0; got = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (m_valid[i] && m_qty[i] != 0) begin
        if (!f) p = m_price[i];
        else if (ask && m_price[i] < p) p = m_price[i];
        else if (!ask && m_price[i] > p) p = m_price[i];
        f = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (f && !got && m_valid[i] && m_qty[i] != 0 && m_price[i] == p) begin
        q = m_qty[i];
        ix = 64'(i);
        got = 1'b1;
      end
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_price[i] = {$urandom, $urandom};
      m_qty[i]   = {32'h0, $urandom};
    end
  endtask

  task automatic rand_mem();
    bit wide;
    wide = ($urandom_range(0, 2) == 0);
    for (int i = 0; i < N; i++) begin
      m_valid[i] = ($urandom_range(0, 3) != 0);
      m_qty[i]   = ($urandom_range(0, 4) == 0) ? 64'd0 : {32'h0, $urandom};
      m_price[i] = wide ? {$urandom, $urandom} : 64'($urandom_range(0, 5));
    end
  endtask

  task automatic release_out();
    out_ready_r = 1'b1;
    @(negedge clk);
    out_ready_r = 1'b0;
    check_eq("idle_valid", 64'(o_valid), 64'd0);
    check_eq("idle_busy", 64'(o_busy), 64'd0);
  endtask

  // Called one negedge after the start-accepting edge.
  task automatic collect(input bit ask, input bit release_it);
    int cyc;
    ref_best(ask, e_found, e_price, e_qty, e_idx);
    for (cyc = 1; cyc <= 40; cyc++) begin
      if (o_valid) break;
      if (cyc <= N) check_eq("scan_rd_index", 64'(o_idx), 64'(cyc - 1));
      check_eq("scan_busy", 64'(o_busy), 64'd1);
      @(negedge clk);
    end
    check_eq("latency", 64'(cyc), 64'(N + 2));
    check_eq("done_busy", 64'(o_busy), 64'd0);
    check_eq("done_rd_index", 64'(o_idx), 64'd0);
    check_eq("best_found", 64'(o_found), 64'(e_found));
    check_eq("best_price", o_price, e_price);
    check_eq("best_quantity", o_qty, e_qty);
    check_eq("best_index", 64'(o_bidx), e_idx);
    if (release_it) release_out();
  endtask

  task automatic run_scan(input bit ask, input bit release_it);
    sel_ask = ask;
    start_r = 1'b1;
    @(negedge clk);
    start_r = 1'b0;
    collect(ask, release_it);
  endtask

  initial begin
    reset_r = 1'b1; start_r = 1'b0; out_ready_r = 1'b0; sel_ask = 1'b0;
    clear_mem();
    repeat (3) @(negedge clk);
    check_eq("rst_busy_b", 64'(busy_b), 64'd0);
    check_eq("rst_valid_b", 64'(ov_b), 64'd0);
    check_eq("rst_found_b", 64'(found_b), 64'd0);
    check_eq("rst_price_b", bp_b, 64'd0);
    check_eq("rst_qty_b", bq_b, 64'd0);
    check_eq("rst_bidx_b", 64'(bidx_b), 64'd0);
    check_eq("rst_idx_b", 64'(idx_b), 64'd0);
    check_eq("rst_valid_a", 64'(ov_a), 64'd0);
    check_eq("rst_busy_a", 64'(busy_a), 64'd0);
    reset_r = 1'b0;
    @(negedge clk);

    // Bid directed case: entry 7 is better but has zero quantity.
    clear_mem();
    m_valid[3] = 1'b1; m_price[3] = 64'd100; m_qty[3] = 64'd5;
    m_valid[7] = 1'b1; m_price[7] = 64'd250; m_qty[7] = 64'd0;
    m_valid[9] = 1'b1; m_price[9] = 64'd180; m_qty[9] = 64'd8;
    run_scan(1'b0, 1'b0);
    check_eq("d1_price", o_price, 64'd180);
    check_eq("d1_index", 64'(o_bidx), 64'd9);
    check_eq("d1_qty", o_qty, 64'd8);
    check_eq("d1_found", 64'(o_found), 64'd1);
    release_out();

    // Ask directed case with a tie at the best price.
    clear_mem();
    m_valid[2] = 1'b1; m_price[2] = 64'd50; m_qty[2] = 64'd1;
    m_valid[5] = 1'b1; m_price[5] = 64'd50; m_qty[5] = 64'd3;
    m_valid[8] = 1'b1; m_price[8] = 64'd60; m_qty[8] = 64'd2;
    run_scan(1'b1, 1'b0);
    check_eq("d2_index", 64'(o_bidx), 64'd2);
    check_eq("d2_price", o_price, 64'd50);
    release_out();

    // Nothing qualifies.
    clear_mem();
    run_scan(1'b0, 1'b0);
    check_eq("d3_found", 64'(o_found), 64'd0);
    check_eq("d3_price", o_price, 64'd0);
    check_eq("d3_qty", o_qty, 64'd0);
    check_eq("d3_index", 64'(o_bidx), 64'd0);
    release_out();

    // Backpressure in DONE with a start pulse that must be ignored.
    rand_mem();
    m_valid[4] = 1'b1; m_qty[4] = 64'd9;
    run_scan(1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      start_r = (k == 4);
      @(negedge clk);
      check_eq("hold_valid", 64'(o_valid), 64'd1);
      check_eq("hold_busy", 64'(o_busy), 64'd0);
      check_eq("hold_price", o_price, e_price);
      check_eq("hold_qty", o_qty, e_qty);
      check_eq("hold_index", 64'(o_bidx), e_idx);
    end
    start_r = 1'b0;
    release_out();
    @(negedge clk);
    check_eq("no_queued_start", 64'(o_busy), 64'd0);

    // Start coincident with the handshake is dropped; the next IDLE start is taken.
    rand_mem();
    run_scan(1'b1, 1'b0);
    out_ready_r = 1'b1;
    start_r = 1'b1;
    @(negedge clk);
    out_ready_r = 1'b0;
    check_eq("b2b_valid", 64'(o_valid), 64'd0);
    check_eq("b2b_busy", 64'(o_busy), 64'd0);
    @(negedge clk);
    start_r = 1'b0;
    collect(1'b1, 1'b1);

    // Reset in the middle of a scan.
    rand_mem();
    m_valid[1] = 1'b1; m_qty[1] = 64'd3;
    sel_ask = 1'b0;
    start_r = 1'b1;
    @(negedge clk);
    start_r = 1'b0;
    for (int k = 0; k < 20 && o_idx != 4'd6; k++) @(negedge clk);
    check_eq("reached_idx6", 64'(o_idx), 64'd6);
    reset_r = 1'b1;
    @(negedge clk);
    reset_r = 1'b0;
    check_eq("mrst_busy", 64'(o_busy), 64'd0);
    check_eq("mrst_valid", 64'(o_valid), 64'd0);
    check_eq("mrst_found", 64'(o_found), 64'd0);
    check_eq("mrst_price", o_price, 64'd0);
    check_eq("mrst_qty", o_qty, 64'd0);
    check_eq("mrst_bidx", 64'(o_bidx), 64'd0);
    check_eq("mrst_idx", 64'(o_idx), 64'd0);
    @(negedge clk);
    rand_mem();
    run_scan(1'b0, 1'b1);

    // Randomized scans on both polarities.
    for (int it = 0; it < 24; it++) begin
      rand_mem();
      run_scan(it[0], 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
